// File: rtl/systolic_skew_feeder_if.sv
// Loader/control/stream bundle between the tile source, the skew feeder and the MAC array west edge.
interface systolic_skew_feeder_if #(
    parameter int BITS = 8,
    parameter int DIM  = 8
);
    logic                   en;
    logic                   wr_en;
    logic [$clog2(DIM)-1:0] wr_row;
    logic [DIM*BITS-1:0]    wr_data;
    logic                   start;
    logic                   busy;
    logic                   out_valid;
    logic [DIM*BITS-1:0]    a_out;
    logic                   done;

    modport master (
        output en, wr_en, wr_row, wr_data, start,
        input  busy, out_valid, a_out, done
    );

    modport slave (
        input  en, wr_en, wr_row, wr_data, start,
        output busy, out_valid, a_out, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewed A-operand feeder: stores a DIM x DIM tile and streams 2*DIM-1 diagonal vectors (lane i delayed i cycles).
// Optional macro SKEW_FEEDER_TRANSPOSE_EN: writes land column-major (wr_row selects column, element i goes to row i).
module systolic_skew_feeder #(
    parameter int BITS = 8,
    parameter int DIM  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int            TW     = $clog2(2*DIM-1);
    localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           t_q, t_d;
    logic                    busy_q, busy_d;
    logic                    out_valid_q, out_valid_d;
    logic                    done_q, done_d;
    logic [DIM*BITS-1:0]     a_out_q, a_out_d;
    logic signed [BITS-1:0]  mem_q [DIM][DIM];

    logic [TW-1:0]           t_sel;
    logic [DIM*BITS-1:0]     vec;
    logic                    wr_fire;

    // Writes only land in IDLE; start in the same cycle wins and drops the write.
    assign wr_fire = (state_q == IDLE) && bus.wr_en && !bus.start && (int'(bus.wr_row) < DIM);

    // Vector index being loaded into a_out at the coming edge.
    assign t_sel = (state_q == IDLE) ? '0 : (t_q + TW'(1));

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [BITS-1:0] lane_val;
        always_comb begin
            lane_val = '0;
            for (int j = 0; j < DIM; j++) begin
                if (int'(t_sel) == j + gi) begin
                    lane_val = mem_q[gi][j];
                end
            end
        end
        assign vec[gi*BITS +: BITS] = lane_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else if (wr_fire) begin
            for (int j = 0; j < DIM; j++) begin
`ifdef SKEW_FEEDER_TRANSPOSE_EN
                mem_q[j][bus.wr_row] <= bus.wr_data[j*BITS +: BITS];
`else
                mem_q[bus.wr_row][j] <= bus.wr_data[j*BITS +: BITS];
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        a_out_d     = a_out_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = STREAM;
                    t_d         = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    a_out_d     = vec;
                end
            end
            STREAM: begin
                // en low freezes everything so the stream stays aligned with a stalled array.
                if (bus.en) begin
                    if (t_q == T_LAST) begin
                        state_d     = IDLE;
                        t_d         = '0;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b0;
                        a_out_d     = '0;
                        done_d      = 1'b1;
                    end else begin
                        t_d     = t_q + TW'(1);
                        a_out_d = vec;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            a_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            a_out_q     <= a_out_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.a_out     = a_out_q;
endmodule
